// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: a single WIDTH-bit register that NUM_REQ requesters
// share. Round-robin arbitration picks a writer. A two-state sequencer
// (IDLE -> GRANT -> IDLE) then performs one write per grant.
module reg_share_arbiter #(
    parameter int               NUM_REQ   = 4,
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy,
    output logic                       wr_done,
    output logic [WIDTH-1:0]           q
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_sel;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   w_win;
    logic [WIDTH-1:0] r_q;
    logic             r_wr_done;
    logic [WIDTH-1:0] w_lane;

    assign w_lane  = wdata[r_sel*WIDTH +: WIDTH];
    assign gnt_id  = r_sel;
    assign q       = r_q;
    assign wr_done = r_wr_done;

    // Round-robin winner: the first set req bit when scanning upward from ptr, with wrap-around.
    always_comb begin
        logic           found;
        logic [IDW-1:0] cand;
        found = 1'b0;
        cand  = '0;
        w_win = r_ptr;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((32'(r_ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                w_win = cand;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state: leave IDLE on any request; GRANT always lasts exactly one cycle.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (|req) w_state_nxt = GRANT;
            GRANT:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state: a one-hot grant and busy, both during GRANT only.
    always_comb begin
        gnt  = '0;
        busy = 1'b0;
        if (r_state == GRANT) begin
            gnt[r_sel] = 1'b1;
            busy       = 1'b1;
        end
    end

    // Datapath. Latch the winner in IDLE. At the closing edge of GRANT, write q, advance ptr and flag completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q       <= RESET_VAL;
            r_sel     <= '0;
            r_ptr     <= '0;
            r_wr_done <= 1'b0;
        end else begin
            r_wr_done <= 1'b0;
            if (r_state == IDLE) begin
                if (|req) r_sel <= w_win;
            end else begin
                r_q       <= w_lane;
                r_ptr     <= (r_sel == IDW'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;
                r_wr_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter. Each step applies inputs for one edge
// and then checks every output 1 ns after that edge.
module tb_reg_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        busy;
    logic        wr_done;
    logic [7:0]  q;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_share_arbiter #(
        .NUM_REQ  (4),
        .WIDTH    (8),
        .RESET_VAL(8'h00)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .wdata  (wdata),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .wr_done(wr_done),
        .q      (q)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] wd;
        logic [3:0]  e_gnt;
        logic [1:0]  e_id;
        logic        e_busy;
        logic        e_done;
        logic [7:0]  e_q;
    } vec_t;

    vec_t vecs[64];
    int   nvec = 0;

    task automatic push(input logic rst, input logic [3:0] rq, input logic [31:0] wd,
                        input logic [3:0] eg, input logic [1:0] eid, input logic eb,
                        input logic ed, input logic [7:0] eq);
        vecs[nvec].rst    = rst;
        vecs[nvec].req    = rq;
        vecs[nvec].wd     = wd;
        vecs[nvec].e_gnt  = eg;
        vecs[nvec].e_id   = eid;
        vecs[nvec].e_busy = eb;
        vecs[nvec].e_done = ed;
        vecs[nvec].e_q    = eq;
        nvec++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic [3:0] rq, input logic [31:0] wd);
        reset = rst;
        req   = rq;
        wdata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                             input logic eb, input logic ed, input logic [7:0] eq);
        chk({tag, ".gnt"},     32'(gnt),     32'(eg));
        chk({tag, ".gnt_id"},  32'(gnt_id),  32'(eid));
        chk({tag, ".busy"},    32'(busy),    32'(eb));
        chk({tag, ".wr_done"}, 32'(wr_done), 32'(ed));
        chk({tag, ".q"},       32'(q),       32'(eq));
    endtask

    initial begin
        logic [1:0] id;
        reset = 1'b1;
        req   = '0;
        wdata = '0;

        // Reset for 5 cycles with every requester active.
        for (int i = 0; i < 5; i++) push(1, 4'b1111, 32'h30303030, 4'b0000, 0, 0, 0, 8'h00);
        push(0, 4'b0000, 32'h0, 4'b0000, 0, 0, 0, 8'h00);
        // Single write from requester 2.
        push(0, 4'b0100, 32'h000F0000, 4'b0100, 2, 1, 0, 8'h00);
        push(0, 4'b0100, 32'h000F0000, 4'b0000, 2, 0, 1, 8'h0F);
        push(0, 4'b0000, 32'h0,        4'b0000, 2, 0, 0, 8'h0F);
        // Reset to clear ptr, then all four requesters held for 8 grants.
        push(1, 4'b0000, 32'h0, 4'b0000, 0, 0, 0, 8'h00);
        for (int g = 0; g < 8; g++) begin
            id = 2'(g % 4);
            push(0, 4'b1111, 32'hA3A2A1A0, 4'(1 << id), id, 1, 0,
                 (g == 0) ? 8'h00 : 8'(8'hA0 + ((g - 1) % 4)));
            push(0, 4'b1111, 32'hA3A2A1A0, 4'b0000, id, 0, 1, 8'(8'hA0 + id));
        end
        // Wrap with priority: ptr=0 after the grant to 3, so req=1010 grants 1 and then 3.
        push(0, 4'b1010, 32'hB3B2B1B0, 4'b0010, 1, 1, 0, 8'hA3);
        push(0, 4'b1010, 32'hB3B2B1B0, 4'b0000, 1, 0, 1, 8'hB1);
        push(0, 4'b1000, 32'hB3B2B1B0, 4'b1000, 3, 1, 0, 8'hB1);
        push(0, 4'b1000, 32'hB3B2B1B0, 4'b0000, 3, 0, 1, 8'hB3);
        push(0, 4'b0000, 32'h0,        4'b0000, 3, 0, 0, 8'hB3);

        for (int i = 0; i < nvec; i++) begin
            cyc(vecs[i].rst, vecs[i].req, vecs[i].wd);
            check_all($sformatf("v%0d", i), vecs[i].e_gnt, vecs[i].e_id,
                      vecs[i].e_busy, vecs[i].e_done, vecs[i].e_q);
        end

        // Mid-operation reset: assert reset in the GRANT cycle, so the write is discarded.
        cyc(1, 4'b0000, 32'h0);
        cyc(0, 4'b0001, 32'h00000055);
        check_all("mr.grant", 4'b0001, 0, 1, 0, 8'h00);
        cyc(1, 4'b0001, 32'h00000055);
        check_all("mr.reset", 4'b0000, 0, 0, 0, 8'h00);
        cyc(0, 4'b0000, 32'h0);
        check_all("mr.after", 4'b0000, 0, 0, 0, 8'h00);

        // Protocol violation: req[1] drops during GRANT, and req[2] rises during GRANT.
        cyc(0, 4'b0010, 32'h00007700);
        check_all("pv.grant1", 4'b0010, 1, 1, 0, 8'h00);
        cyc(0, 4'b0100, 32'h00887700);
        check_all("pv.write1", 4'b0000, 1, 0, 1, 8'h77);
        cyc(0, 4'b0100, 32'h00887700);
        check_all("pv.grant2", 4'b0100, 2, 1, 0, 8'h77);
        cyc(0, 4'b0100, 32'h00887700);
        check_all("pv.write2", 4'b0000, 2, 0, 1, 8'h88);
        cyc(0, 4'b0000, 32'h0);
        check_all("pv.idle",   4'b0000, 2, 0, 0, 8'h88);
        // q holds while idle.
        repeat (3) cyc(0, 4'b0000, 32'hFFFFFFFF);
        check_all("hold", 4'b0000, 2, 0, 0, 8'h88);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
